// File: rtl/mem_pkg.sv
// Shared types and defaults for the L1 fill responder and its line RAM.
// The state encoding, the default geometry and the request bundle live here.
package mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int LINE_W_DEF = 128;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [LINE_W_DEF-1:0] wdata;
    } req_t;

endpackage

// File: rtl/line_ram.sv
// Single-port line-wide backing store: synchronous write, read-first synchronous read.
// Contents start at zero and are never touched by reset.
module line_ram #(
    parameter int ADDR_W = 8,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem_q [2**ADDR_W] = '{default: '0};
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/l1_fill_responder.sv
// Memory-side responder: accepts one line request, waits LATENCY cycles, commits to the
// line RAM, then holds a response until the L1 consumes it.
module l1_fill_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_write,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [LINE_W-1:0] resp_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              is_read_q, is_read_d;
    logic              commit;
    logic [LINE_W-1:0] ram_rdata;

    // Reset gates the RAM enable so a write on the reset edge never lands.
    assign commit = (state_q == BUSY) && (cnt_q == '0);

    line_ram #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_line_ram (
        .clk   (clk),
        .en    (commit && rst_n),
        .we    (write_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_read_d = is_read_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = BUSY;
                    cnt_d     = CNT_LOAD;
                    write_d   = req_write;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    is_read_d = 1'b0;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d   = RESP;
                    is_read_d = !write_q;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_read_q <= is_read_d;
        end
    end

    // The RAM output register is the fill-data register; write responses mask it to zero.
    assign resp_rdata = is_read_q ? ram_rdata : '0;
    assign resp_write = write_q;
    assign resp_addr  = addr_q;
    assign resp_valid = (state_q == RESP);
    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/l1_fill_responder.md
# l1_fill_responder

Memory-side responder for the L1 set-associative cache controller. Accepts one line-granular request at a time (read-miss fill or dirty-line write-back) over a valid/ready handshake. Holds it for a fixed latency, commits it to an internal line-wide backing store, then returns a response over a second valid/ready handshake. It sits between the L1 controller in `main` and the rest of the memory hierarchy. In the multicore build, one instance serves each L1.

## Interface
Parameters:
- ADDR_W, 8, line-address width; backing store holds 2^ADDR_W lines
- LINE_W, 128, cache-line width in bits (multiple of 32)
- LATENCY, 4, cycles from request acceptance to response valid; legal range 1..255

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  L1 presents a request
- req_ready  out  1  responder can accept (high only in IDLE)
- req_write  in  1  1 = write-back, 0 = fill read
- req_addr  in  ADDR_W  line address
- req_wdata  in  LINE_W  write-back line data (ignored for reads)
- resp_valid  out  1  response available
- resp_ready  in  1  L1 consumes response
- resp_write  out  1  echo of req_write for the held request
- resp_addr  out  ADDR_W  echo of req_addr
- resp_rdata  out  LINE_W  fill data; 0 for write responses
- busy  out  1  high in BUSY or RESP

## Operation
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - req_ready=1.
  - When req_valid=1 at a rising edge, the request is accepted: req_write, req_addr and req_wdata are latched, the counter loads LATENCY-1, and the FSM moves to BUSY.
- BUSY:
  - If cnt≠0: cnt decrements.
  - If cnt==0 (commit edge):
    - Write requests store the latched data into store[addr] and set resp_rdata=0.
    - Read requests load store[addr] into the resp_rdata register.
    - The FSM moves to RESP.
  - req_valid is ignored while in BUSY.
- RESP:
  - resp_valid=1, and resp_* hold steady until the handshake.
  - When resp_ready=1 at an edge, the FSM returns to IDLE.
  - resp_valid must not drop without resp_ready.
- Read-after-write to the same address returns the written data, because the write commits before its response.
- Backing store:
  - Zero-initialised at configuration.
  - Not cleared by reset; contents persist across rst_n.
- Address arithmetic: req_addr indexes the store directly. There is no wrap or offset; all 2^ADDR_W values are legal.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE, cnt=0.
  - resp_valid=0, resp_write=0, resp_addr=0, resp_rdata=0, busy=0.
  - req_ready=1 from the first cycle after reset.
- Reset mid-operation:
  - A request in BUSY before its commit edge is dropped; its write is not committed.
  - A pending response in RESP is discarded.
  - Reset takes priority over commit on the same edge.
- Latency: with acceptance at edge t, resp_valid rises after edge t+LATENCY. For LATENCY=1, the commit happens at edge t+1.
- req_ready and busy are decoded combinationally from state. resp_* come from registers.
- Back-to-back operation:
  - A response handshake at edge u returns the FSM to IDLE; the earliest next acceptance is edge u+1.
  - Peak rate is one request per LATENCY+2 cycles when resp_ready is held high.
- Simultaneous events:
  - A req_valid asserted during RESP is neither accepted nor lost. L1 must hold it until req_ready.
  - resp_ready while resp_valid=0 has no effect.

## Structure
- Shared package mem_pkg holds:
  - the state enum (IDLE, BUSY, RESP)
  - the default ADDR_W and LINE_W constants
  - a request struct typedef {write, addr, wdata}
- Sub-module line_ram:
  - ADDR_W x LINE_W single-port RAM
  - synchronous write and synchronous read, selected by a we/en pair at the commit edge
  - zero init
  - infers block RAM
- The top level holds the FSM, latency counter, request latch and response registers.

## Test plan
- Reset with LATENCY=4 → req_ready=1, resp_valid=0 and busy=0 the cycle after rst_n rises; a read of addr 0x05 then returns resp_rdata=0 four edges after acceptance.
- Write addr 0x2A with data 0x…DEADBEEF, then read 0x2A → write response has resp_write=1 and resp_rdata=0; read response returns 0x…DEADBEEF with resp_addr=0x2A.
- Hold resp_ready=0 for 10 cycles during RESP → resp_valid, resp_addr and resp_rdata stay stable, and req_ready stays 0 even with req_valid=1; releasing resp_ready gives IDLE next edge, then acceptance one edge later.
- Assert rst_n=0 two cycles after accepting a write to 0x10 (LATENCY=4), then read 0x10 → returns 0 (write dropped), and all outputs are at reset values.
- Set LATENCY=1 with resp_ready held high and req_valid streaming reads to 0x00..0x03 → each response arrives 1 edge after acceptance, and acceptances are spaced exactly 3 cycles apart.
- Write 0xFF with all-ones data, then write 0x00 → a read of 0xFF still returns all-ones, and a read of 0x00 returns the new data (boundary addresses, no aliasing).
